batcharger_ctrl_param: RTL and testbench

Parametrised second-generation charge-control engine for the battery charger core. It sits between the SAR ADC and the power block. It sequences voltage, current and temperature conversions over a request/done handshake and runs the trickle / constant-current / constant-voltage charging FSM. Compared with the previous controller it adds:
- generic data width
- runtime-programmable thresholds
- a temperature pause state
- end-of-charge debounce
- automatic recharge
- a disable-able safety timeout

---
 rtl/batcharger_pkg.sv | 41 ++++
 rtl/batcharger_meas_seq.sv | 62 ++++++
 rtl/batcharger_ctrl_param.sv | 163 ++++++++++++++++
 tb/tb_batcharger_ctrl_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/batcharger_pkg.sv
// Shared types and default thresholds for the
// parametrised battery charge controller.
package batcharger_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHK   = 3'd1,
    S_TC    = 3'd2,
    S_CC    = 3'd3,
    S_CV    = 3'd4,
    S_DONE  = 3'd5,
    S_PAUSE = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CH_V = 2'd0,
    CH_I = 2'd1,
    CH_T = 2'd2
  } chan_t;

  localparam int unsigned DEF_VCUTOFF = 153;
  localparam int unsigned DEF_VPRESET = 193;
  localparam int unsigned DEF_IEND    = 2;
  localparam int unsigned DEF_TEMPMIN = 61;
  localparam int unsigned DEF_TEMPMAX = 131;

  function automatic chan_t next_chan(
    input chan_t c
  );
    chan_t n;
    n = CH_V;
    unique case (1'b1)
      c == CH_V: n = CH_I;
      c == CH_I: n = CH_T;
      default:   n = CH_V;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/batcharger_meas_seq.sv
// V/I/T conversion round sequencer with one
// idle gap cycle between requests.
module batcharger_meas_seq
  import batcharger_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstz,
  input  logic         clr,
  input  logic         vtok,
  input  logic [W-1:0] vbat,
  input  logic [W-1:0] ibat,
  input  logic [W-1:0] tbat,
  output logic         vmonen,
  output logic         imonen,
  output logic         tmonen,
  output logic [W-1:0] vres,
  output logic [W-1:0] ires,
  output logic [W-1:0] tval,
  output logic         round_done
);

  logic         req;
  chan_t        ch;
  logic         hit;
  logic [W-1:0] tres;

  assign hit        = req && vtok && !clr;
  assign round_done = hit && (ch == CH_T);

  // T is evaluated in the cycle it arrives
  assign tval = round_done ? tbat : tres;

  assign vmonen = req && (ch == CH_V);
  assign imonen = req && (ch == CH_I);
  assign tmonen = req && (ch == CH_T);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      req  <= 1'b0;
      ch   <= CH_V;
      vres <= '0;
      ires <= '0;
      tres <= '0;
    end else if (clr) begin
      req <= 1'b0;
      ch  <= CH_V;
    end else if (hit) begin
      req <= 1'b0;
      ch  <= next_chan(ch);
      unique case (1'b1)
        ch == CH_V: vres <= vbat;
        ch == CH_I: ires <= ibat;
        default:    tres <= tbat;
      endcase
    end else if (!req) begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/batcharger_ctrl_param.sv
// Charge FSM (trickle/CC/CV/done/pause/fault)
// with charge timer and end-of-charge debounce.
module batcharger_ctrl_param
  import batcharger_pkg::*;
#(
  parameter int W    = 8,
  parameter int TW   = 8,
  parameter int TDIV = 10,
  parameter int NEND = 3
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          en,
  input  logic          vtok,
  input  logic [W-1:0]  vbat,
  input  logic [W-1:0]  ibat,
  input  logic [W-1:0]  tbat,
  input  logic [W-1:0]  vcutoff,
  input  logic [W-1:0]  vpreset,
  input  logic [W-1:0]  vrecharge,
  input  logic [W-1:0]  iend,
  input  logic [W-1:0]  tempmin,
  input  logic [W-1:0]  tempmax,
  input  logic [TW-1:0] tmax,
  output logic          vmonen,
  output logic          imonen,
  output logic          tmonen,
  output logic          tc,
  output logic          cc,
  output logic          cv,
  output logic          done,
  output logic          fault,
  output logic [2:0]    state
);

  localparam int EW = $clog2(NEND + 1);

  state_t          st;
  logic [TW-1:0]   timer;
  logic [TDIV-1:0] pre;
  logic [EW-1:0]   ecnt;

  logic [W-1:0] vres;
  logic [W-1:0] ires;
  logic [W-1:0] tval;
  logic         round_done;
  logic         charging;
  logic         active;
  logic         fault_hit;
  logic         clr;
  logic         temp_bad;
  logic         tsat;

  assign charging  = st inside {S_TC, S_CC, S_CV};
  assign active    = !(st inside {S_IDLE, S_FAULT});
  assign fault_hit = charging && (tmax != '0)
                  && (timer == tmax);
  assign clr       = !en || !active || fault_hit;
  assign temp_bad  = (tval < tempmin)
                  || (tval > tempmax);
  assign tsat      = (&timer)
                  || ((tmax != '0) && (timer == tmax));

  batcharger_meas_seq #(
    .W(W)
  ) u_meas (
    .clk       (clk),
    .rstz      (rstz),
    .clr       (clr),
    .vtok      (vtok),
    .vbat      (vbat),
    .ibat      (ibat),
    .tbat      (tbat),
    .vmonen    (vmonen),
    .imonen    (imonen),
    .tmonen    (tmonen),
    .vres      (vres),
    .ires      (ires),
    .tval      (tval),
    .round_done(round_done)
  );

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      st    <= S_IDLE;
      timer <= '0;
      pre   <= '0;
      ecnt  <= '0;
    end else if (!en) begin
      st    <= S_IDLE;
      timer <= '0;
      pre   <= '0;
      ecnt  <= '0;
    end else begin
      if (st != S_CV) ecnt <= '0;
      case (st)
        S_IDLE: begin
          st    <= S_CHK;
          timer <= '0;
          pre   <= '0;
        end
        S_FAULT: ;
        default: begin
          if (charging) begin
            pre <= pre + 1'b1;
            if ((&pre) && !tsat)
              timer <= timer + 1'b1;
          end
          if (st == S_DONE) begin
            timer <= '0;
            pre   <= '0;
          end
          if (fault_hit) begin
            st <= S_FAULT;
          end else if (round_done) begin
            if (temp_bad) begin
              st <= S_PAUSE;
            end else begin
              case (st)
                S_PAUSE: st <= S_CHK;
                S_CHK: begin
                  if (vres < vcutoff)
                    st <= S_TC;
                  else if (vres < vpreset)
                    st <= S_CC;
                  else
                    st <= S_CV;
                end
                S_TC:
                  if (vres >= vcutoff) st <= S_CC;
                S_CC:
                  if (vres >= vpreset) st <= S_CV;
                S_CV: begin
                  if (ires <= iend) begin
                    if (ecnt == EW'(NEND - 1)) begin
                      st   <= S_DONE;
                      ecnt <= '0;
                    end else begin
                      ecnt <= ecnt + 1'b1;
                    end
                  end else begin
                    ecnt <= '0;
                  end
                end
                S_DONE:
                  if (vres < vrecharge) st <= S_CHK;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign tc    = (st == S_TC);
  assign cc    = (st == S_CC);
  assign cv    = (st == S_CV);
  assign done  = (st == S_DONE);
  assign fault = (st == S_FAULT);
  assign state = st;

endmodule

// File: tb/tb_batcharger_ctrl_param.sv
// Directed bench for batcharger_ctrl_param:
// handshake, charge flow, pause, debounce, timeout.
module tb_batcharger_ctrl_param;
  import batcharger_pkg::*;

  logic       clk = 1'b0;
  logic       rstz;
  logic       en;
  logic       vtok;
  logic       vtok_a;
  logic       vtok_m;
  logic       auto_rsp;
  logic [7:0] vbat, ibat, tbat;
  logic [7:0] vcutoff, vpreset, vrecharge;
  logic [7:0] iend, tempmin, tempmax;
  logic [7:0] tmax;
  logic       vmonen, imonen, tmonen;
  logic       tc, cc, cv, done, fault;
  logic [2:0] state;
  logic [2:0] reqs;
  logic [7:0] t0;
  int         nchk = 0;
  int         nerr = 0;
  int         dly;

  assign vtok = vtok_a | vtok_m;
  assign reqs = {vmonen, imonen, tmonen};

  always #5 clk = ~clk;

  batcharger_ctrl_param #(
    .W(8), .TW(8), .TDIV(2), .NEND(3)
  ) dut (
    .clk      (clk),
    .rstz     (rstz),
    .en       (en),
    .vtok     (vtok),
    .vbat     (vbat),
    .ibat     (ibat),
    .tbat     (tbat),
    .vcutoff  (vcutoff),
    .vpreset  (vpreset),
    .vrecharge(vrecharge),
    .iend     (iend),
    .tempmin  (tempmin),
    .tempmax  (tempmax),
    .tmax     (tmax),
    .vmonen   (vmonen),
    .imonen   (imonen),
    .tmonen   (tmonen),
    .tc       (tc),
    .cc       (cc),
    .cv       (cv),
    .done     (done),
    .fault    (fault),
    .state    (state)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(
    input state_t s,
    input string  tag
  );
    int n;
    n = 0;
    while (state != s && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic wait_round(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tmonen && vtok) && n < 100);
    if (n >= 100) chk(tag, 0, 1);
  endtask

  // ADC model: answers each request on its 2nd cycle
  initial begin
    vtok_a = 1'b0;
    dly    = 0;
    forever begin
      @(posedge clk);
      #1;
      vtok_a = 1'b0;
      if (auto_rsp && (reqs != 3'b000)) begin
        dly++;
        if (dly == 2) begin
          vtok_a = 1'b1;
          dly    = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  initial begin
    logic [7:0] seq [6];
    seq = '{8'd1, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1};
    rstz      = 1'b0;
    en        = 1'b0;
    vtok_m    = 1'b0;
    auto_rsp  = 1'b0;
    vbat      = 8'd0;
    ibat      = 8'd0;
    tbat      = 8'd0;
    vcutoff   = 8'(DEF_VCUTOFF);
    vpreset   = 8'(DEF_VPRESET);
    vrecharge = 8'd188;
    iend      = 8'(DEF_IEND);
    tempmin   = 8'(DEF_TEMPMIN);
    tempmax   = 8'(DEF_TEMPMAX);
    tmax      = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_outs",
        {reqs, tc, cc, cv, done, fault}, 0);
    rstz = 1'b1;
    cyc();

    // handshake, driven by hand
    vbat = 8'd10;
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("idle_vtok", {state, reqs}, 0);
    en = 1'b1;
    cyc();
    chk("chk_entry", state, S_CHK);
    chk("chk_noreq", reqs, 0);
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("stray_ign", reqs, 3'b100);
    cyc();
    chk("req_hold", reqs, 3'b100);
    vbat = 8'd200;
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("gap_v", reqs, 0);
    cyc();
    chk("req_i", reqs, 3'b010);
    ibat = 8'd5;
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("gap_i", reqs, 0);
    cyc();
    chk("req_t", reqs, 3'b001);
    tbat = 8'd100;
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("chk_to_cv", state, S_CV);
    chk("cv_mode", {tc, cc, cv}, 3'b001);
    cyc();
    chk("req_v2", reqs, 3'b100);
    en = 1'b0;
    vtok_m = 1'b1;
    cyc();
    vtok_m = 1'b0;
    chk("en_drop",
        {state, reqs, tc, cc, cv, done, fault}, 0);

    // normal charge
    auto_rsp = 1'b1;
    vbat = 8'd120;
    ibat = 8'd5;
    tbat = 8'd100;
    en = 1'b1;
    wait_state(S_TC, "to_tc");
    chk("tc_out", {tc, cc, cv, done}, 4'b1000);
    vbat = 8'd160;
    wait_state(S_CC, "to_cc");
    chk("cc_out", {tc, cc, cv, done}, 4'b0100);
    vbat = 8'd200;
    wait_state(S_CV, "to_cv");
    ibat = 8'd1;
    wait_state(S_DONE, "to_done");
    chk("done_out", {tc, cc, cv, done}, 4'b0001);

    // recharge
    @(negedge clk);
    chk("done_timer", dut.timer, 0);
    vbat = 8'd180;
    wait_state(S_CHK, "rchg_chk");
    chk("rchg_timer", dut.timer, 0);
    wait_state(S_CC, "rchg_cc");

    // temperature pause
    tbat = 8'd140;
    wait_state(S_PAUSE, "to_pause");
    chk("pause_mode", {tc, cc, cv, done}, 0);
    t0 = dut.timer;
    repeat (30) @(negedge clk);
    chk("pause_frz", dut.timer, t0);
    tbat = 8'd100;
    wait_state(S_CHK, "unpause");
    chk("pause_keep", dut.timer, t0);
    wait_state(S_CC, "resume_cc");

    // debounce, tbat on the inclusive max edge
    en = 1'b0;
    @(negedge clk);
    vbat = 8'd200;
    ibat = 8'd5;
    tbat = 8'd131;
    en = 1'b1;
    wait_state(S_CV, "db_cv");
    wait_round("db_rnd0");
    for (int i = 0; i < 6; i++) begin
      ibat = seq[i];
      wait_round("db_rnd");
      @(posedge clk);
      #1;
      if (i < 5)
        chk("db_hold", state, S_CV);
      else
        chk("db_done", state, S_DONE);
    end

    // timeout, tbat on the inclusive min edge
    en = 1'b0;
    @(negedge clk);
    tmax = 8'd5;
    vbat = 8'd120;
    tbat = 8'd61;
    en = 1'b1;
    wait_state(S_TC, "tmo_tc");
    repeat (20) @(negedge clk);
    chk("tmo_timer", dut.timer, 5);
    chk("tmo_early", fault, 0);
    @(negedge clk);
    chk("tmo_fault", fault, 1);
    chk("tmo_reqs", {reqs, tc}, 0);
    en = 1'b0;
    @(negedge clk);
    chk("tmo_clear", {state, fault}, 0);
    tmax = 8'd0;

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
